muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit.sv | 178 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU use shift-add and DIV/DIVU use restoring division. Each
// processes one bit per cycle on operand magnitudes, and a FIX cycle then
// applies the sign correction. MTHI/MTLO write HI/LO directly in one cycle.
//
// Handshake: start is sampled only while the unit is idle. busy is high from
// the cycle after an accepted multi-cycle start until the HI/LO write. done
// pulses for one cycle when HI/LO hold new values. This covers both
// multi-cycle ops and MTHI/MTLO. A start seen while busy is dropped.
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
);

   localparam int CW = $clog2(XLEN);

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_FIX  = 2'd3
   } state_t;

   // State is kept as a plainly named enum so checkers can bind to it.
   state_t state;

   // MUL: op_a is the multiplicand and op_b the multiplier, shifted right.
   // DIV: op_a is the dividend, shifted left, and op_b the divisor.
   logic [XLEN-1:0]   op_a;
   logic [XLEN-1:0]   op_b;
   // MUL: running product. DIV: {remainder, quotient}.
   logic [2*XLEN-1:0] acc;
   logic [CW-1:0]     count;
   logic              sign_a;
   logic              sign_b;
   logic              b_zero;
   logic              is_div;

   logic              signed_op;
   logic [XLEN-1:0]   abs_a;
   logic [XLEN-1:0]   abs_b;
   logic              last_iter;
   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     rem_shift;
   logic [XLEN:0]     rem_diff;
   logic [2*XLEN-1:0] mul_next;
   logic [2*XLEN-1:0] div_next;
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quo_fix;
   logic [XLEN-1:0]   rem_fix;

   // Operand magnitudes, iteration datapath and sign correction.
   always_comb begin
      signed_op = (op == OP_MULT) || (op == OP_DIV);
      abs_a     = (signed_op && a[XLEN-1]) ? (~a + 1'b1) : a;
      abs_b     = (signed_op && b[XLEN-1]) ? (~b + 1'b1) : b;
      last_iter = (count == CW'(XLEN - 1));

      // Shift-add step: add the multiplicand into the upper half when the
      // current multiplier bit is set, then shift the product right by one.
      mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (op_b[0] ? op_a : '0)};
      mul_next  = {mul_sum, acc[XLEN-1:1]};

      // Restoring step: bring in the next dividend bit. The subtraction is
      // kept only when it does not borrow.
      rem_shift = {acc[2*XLEN-1:XLEN], op_a[XLEN-1]};
      rem_diff  = rem_shift - {1'b0, op_b};
      if (rem_diff[XLEN])
         div_next = {rem_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      else
         div_next = {rem_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};

      // A zero divisor leaves remainder=|a|. Giving it the sign of a then
      // restores a itself, so only the quotient needs forcing.
      prod_fix = (sign_a ^ sign_b) ? (~acc + 1'b1) : acc;
      rem_fix  = sign_a ? (~acc[2*XLEN-1:XLEN] + 1'b1) : acc[2*XLEN-1:XLEN];
      if (b_zero)
         quo_fix = '1;
      else if (sign_a ^ sign_b)
         quo_fix = ~acc[XLEN-1:0] + 1'b1;
      else
         quo_fix = acc[XLEN-1:0];
   end

   // Control FSM, iteration registers and HI/LO, all with registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         op_a   <= '0;
         op_b   <= '0;
         acc    <= '0;
         count  <= '0;
         sign_a <= 1'b0;
         sign_b <= 1'b0;
         b_zero <= 1'b0;
         is_div <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         hi     <= '0;
         lo     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  case (op)
                     OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                        op_a   <= abs_a;
                        op_b   <= abs_b;
                        sign_a <= signed_op & a[XLEN-1];
                        sign_b <= signed_op & b[XLEN-1];
                        b_zero <= (b == '0);
                        is_div <= op[1];
                        acc    <= '0;
                        count  <= '0;
                        busy   <= 1'b1;
                        state  <= op[1] ? S_DIV : S_MUL;
                     end
                     OP_MTHI: begin
                        hi   <= a;
                        done <= 1'b1;
                     end
                     OP_MTLO: begin
                        lo   <= a;
                        done <= 1'b1;
                     end
                     default: ;
                  endcase
               end
            end
            S_MUL: begin
               acc   <= mul_next;
               op_b  <= op_b >> 1;
               count <= count + 1'b1;
               if (last_iter) state <= S_FIX;
            end
            S_DIV: begin
               acc   <= div_next;
               op_a  <= op_a << 1;
               count <= count + 1'b1;
               if (last_iter) state <= S_FIX;
            end
            S_FIX: begin
               if (is_div) begin
                  hi <= rem_fix;
                  lo <= quo_fix;
               end else begin
                  hi <= prod_fix[2*XLEN-1:XLEN];
                  lo <= prod_fix[XLEN-1:0];
               end
               count <= '0;
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed scenarios plus a random
// mix, with expected HI/LO values queued when each operation is issued.
module tb_muldiv_unit;

   // ---------------- clock / reset ----------------
   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  op    = 3'b000;
   logic [31:0] a     = '0;
   logic [31:0] b     = '0;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   always #5 clk = ~clk;

   muldiv_unit #(.XLEN(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   // ---------------- scoreboard state ----------------
   int          n_vec = 0;
   int          n_err = 0;
   logic [63:0] exp_q[$];
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   // Reference behaviour written with plain SystemVerilog arithmetic.
   function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] av,
                                         input logic [31:0] bv, input logic [31:0] ch,
                                         input logic [31:0] cl);
      logic signed [63:0] sp;
      logic signed [31:0] sa;
      logic signed [31:0] sb;
      sa = av;
      sb = bv;
      case (o)
         3'd0: begin
            sp = $signed({{32{av[31]}}, av}) * $signed({{32{bv[31]}}, bv});
            return sp;
         end
         3'd1: return {32'b0, av} * {32'b0, bv};
         3'd2: begin
            if (bv == 32'h0) return {av, 32'hFFFFFFFF};
            if (av == 32'h80000000 && bv == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
            return {32'(sa % sb), 32'(sa / sb)};
         end
         3'd3: begin
            if (bv == 32'h0) return {av, 32'hFFFFFFFF};
            return {av % bv, av / bv};
         end
         3'd4: return {av, cl};
         3'd5: return {ch, av};
         default: return {ch, cl};
      endcase
   endfunction

   // ---------------- driver ----------------
   // Issues one op, scrambles the operands after the start edge, then waits
   // (bounded) for done. Reports busy cycles, HI/LO stability while busy,
   // and whether done dropped again one cycle later.
   task automatic drive_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                           output logic [31:0] ohi, output logic [31:0] olo,
                           output int bcyc, output bit got_done, output bit stable,
                           output bit done_low);
      logic [31:0] h0;
      logic [31:0] l0;
      int n;
      @(negedge clk);
      start = 1'b1; op = o; a = av; b = bv;
      @(negedge clk);
      start = 1'b0; a = $urandom; b = $urandom;
      h0 = hi; l0 = lo; bcyc = 0; stable = 1'b1; n = 0;
      while (!done && n < 100) begin
         if (busy) bcyc++;
         if (busy && (hi !== h0 || lo !== l0)) stable = 1'b0;
         @(negedge clk);
         n++;
      end
      got_done = done;
      ohi = hi;
      olo = lo;
      @(negedge clk);
      done_low = !done;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_vec++;
      if ({busy, done, hi, lo} !== 66'h0) begin
         n_err++;
         $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h, want all zero", busy, done, hi, lo);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_multu_max();
      logic [31:0] rh, rl; int bc; bit gd, st, dl; logic [63:0] e;
      exp_q.push_back(64'hFFFFFFFE_00000001);
      drive_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, rh, rl, bc, gd, st, dl);
      e = exp_q.pop_front();
      {m_hi, m_lo} = e;
      n_vec++;
      if ({rh, rl} !== e) begin
         n_err++; $display("FAIL multu_max: got %h_%h want %h", rh, rl, e);
      end
      n_vec++;
      if (bc !== 33 || gd !== 1'b1) begin
         n_err++; $display("FAIL multu_latency: busy_cycles=%0d done=%b want 33 and 1", bc, gd);
      end
      n_vec++;
      if (dl !== 1'b1 || st !== 1'b1) begin
         n_err++; $display("FAIL multu_pulse: done_fell=%b hilo_stable=%b want 1 1", dl, st);
      end
   endtask

   task automatic test_mult_signed();
      logic [31:0] rh, rl; int bc; bit gd, st, dl; logic [63:0] e;
      exp_q.push_back(64'hFFFFFFFF_FFFFFFEB);
      drive_op(3'd0, 32'hFFFFFFFD, 32'h00000007, rh, rl, bc, gd, st, dl);
      e = exp_q.pop_front();
      {m_hi, m_lo} = e;
      n_vec++;
      if ({rh, rl} !== e || !gd) begin
         n_err++; $display("FAIL mult_signed: got %h_%h done=%b want %h", rh, rl, gd, e);
      end
   endtask

   task automatic test_div_cases();
      logic [31:0] rh, rl; int bc; bit gd, st, dl; logic [63:0] e;
      logic [31:0] va[3];
      logic [31:0] vb[3];
      logic [2:0]  vo[3];
      va[0] = 32'hFFFFFFF9; vb[0] = 32'h2;        vo[0] = 3'd2;
      va[1] = 32'h7;        vb[1] = 32'h0;        vo[1] = 3'd3;
      va[2] = 32'h80000000; vb[2] = 32'hFFFFFFFF; vo[2] = 3'd2;
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(model(vo[i], va[i], vb[i], m_hi, m_lo));
         drive_op(vo[i], va[i], vb[i], rh, rl, bc, gd, st, dl);
         e = exp_q.pop_front();
         {m_hi, m_lo} = e;
         n_vec++;
         if ({rh, rl} !== e) begin
            n_err++; $display("FAIL div_case%0d: got hi=%h lo=%h want %h", i, rh, rl, e);
         end
         n_vec++;
         if (bc !== 33 || !gd || !dl) begin
            n_err++; $display("FAIL div_timing%0d: busy_cycles=%0d done=%b fell=%b want 33 1 1", i, bc, gd, dl);
         end
      end
      // Fixed values from the plan, independent of the model.
      n_vec++;
      if ({m_hi, m_lo} !== 64'h00000000_80000000) begin
         n_err++; $display("FAIL div_overflow_const: model %h want 0000000080000000", {m_hi, m_lo});
      end
   endtask

   task automatic test_busy_ignore_mtlo();
      int n;
      logic [63:0] e;
      exp_q.push_back(64'h0000_0000_0000_000C);
      @(negedge clk);
      start = 1'b1; op = 3'd1; a = 32'd3; b = 32'd4;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!done && n < 100) begin @(negedge clk); n++; end
      e = exp_q.pop_front();
      {m_hi, m_lo} = e;
      n_vec++;
      if ({hi, lo} !== e || !done) begin
         n_err++; $display("FAIL busy_ignore: got %h_%h done=%b want %h", hi, lo, done, e);
      end
      // MTLO issued in the done cycle.
      start = 1'b1; op = 3'd5; a = 32'h1234;
      @(negedge clk);
      start = 1'b0;
      m_lo = 32'h1234;
      n_vec++;
      if (lo !== 32'h1234 || hi !== 32'h0 || busy !== 1'b0 || done !== 1'b1) begin
         n_err++; $display("FAIL mtlo_in_done: lo=%h hi=%h busy=%b done=%b want 1234 0 0 1", lo, hi, busy, done);
      end
      @(negedge clk);
      n_vec++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_err++; $display("FAIL mtlo_after: busy=%b done=%b want 0 0", busy, done);
      end
   endtask

   task automatic test_noop();
      for (int i = 6; i < 8; i++) begin
         @(negedge clk);
         start = 1'b1; op = 3'(i); a = $urandom; b = $urandom;
         @(negedge clk);
         start = 1'b0;
         n_vec++;
         if (busy !== 1'b0 || done !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
            n_err++; $display("FAIL noop_op%0d: busy=%b done=%b hi=%h lo=%h want 0 0 %h %h", i, busy, done, hi, lo, m_hi, m_lo);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rh, rl; int bc; bit gd, st, dl; logic [63:0] e;
      // Give HI/LO nonzero content first so the clear is observable.
      exp_q.push_back(model(3'd4, 32'hDEADBEEF, 32'h0, m_hi, m_lo));
      drive_op(3'd4, 32'hDEADBEEF, 32'h0, rh, rl, bc, gd, st, dl);
      e = exp_q.pop_front();
      {m_hi, m_lo} = e;
      n_vec++;
      if ({rh, rl} !== e || bc !== 0 || !gd) begin
         n_err++; $display("FAIL mthi: got %h_%h busy_cycles=%0d want %h 0", rh, rl, bc, e);
      end
      @(negedge clk);
      start = 1'b1; op = 3'd2; a = 32'hFFFFFFF9; b = 32'h2;
      @(negedge clk);
      start = 1'b0;
      repeat (14) @(negedge clk);
      rst_n = 1'b0;
      #1;
      m_hi = '0; m_lo = '0;
      n_vec++;
      if ({busy, done, hi, lo} !== 66'h0) begin
         n_err++; $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h want all zero", busy, done, hi, lo);
      end
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.push_back(model(3'd0, 32'h80000000, 32'h00000003, m_hi, m_lo));
      drive_op(3'd0, 32'h80000000, 32'h00000003, rh, rl, bc, gd, st, dl);
      e = exp_q.pop_front();
      {m_hi, m_lo} = e;
      n_vec++;
      if ({rh, rl} !== e || bc !== 33 || !gd) begin
         n_err++; $display("FAIL after_reset_mult: got %h_%h busy_cycles=%0d want %h 33", rh, rl, bc, e);
      end
   endtask

   task automatic test_random();
      logic [31:0] rh, rl, av, bv; int bc; bit gd, st, dl; logic [63:0] e; logic [2:0] o;
      logic [31:0] special[6];
      special[0] = 32'h0;        special[1] = 32'h1;        special[2] = 32'hFFFFFFFF;
      special[3] = 32'h80000000; special[4] = 32'h7FFFFFFF; special[5] = 32'hFFFFFFFE;
      for (int i = 0; i < 14; i++) begin
         o  = 3'($urandom_range(0, 5));
         av = ($urandom_range(0, 3) == 0) ? special[$urandom_range(0, 5)] : $urandom;
         bv = ($urandom_range(0, 3) == 0) ? special[$urandom_range(0, 5)] : $urandom;
         exp_q.push_back(model(o, av, bv, m_hi, m_lo));
         drive_op(o, av, bv, rh, rl, bc, gd, st, dl);
         e = exp_q.pop_front();
         {m_hi, m_lo} = e;
         n_vec++;
         if ({rh, rl} !== e || !gd || !st || !dl || bc !== ((o < 3'd4) ? 33 : 0)) begin
            n_err++;
            $display("FAIL random%0d op=%0d a=%h b=%h: got %h_%h busy=%0d done=%b stable=%b fell=%b want %h",
                     i, o, av, bv, rh, rl, bc, gd, st, dl, e);
         end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_multu_max();
      test_mult_signed();
      test_div_cases();
      test_busy_ignore_mtlo();
      test_noop();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
